// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the load/store memory stage: data width, funct3
// access encodings and the LSU state enumeration.
package lsu_mem_stage_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  // Load encodings
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  // Store encodings
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_RESP
  } lsu_state_e;

endpackage

// File: rtl/lsu_load_extend.sv
// Load data lane select and sign/zero extension (purely combinational).
module lsu_load_extend
  import lsu_mem_stage_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            addr_lsb,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] data_ext
);

  logic [DATA_WIDTH-1:0] lane;

  // Move the addressed byte/half down to bit 0
  assign lane = rdata >> {addr_lsb, 3'b000};

  // Extend according to access size and signedness
  always_comb begin
    data_ext = '0;
    case (funct3)
      FUNCT3_LB:  data_ext = {{24{lane[7]}}, lane[7:0]};
      FUNCT3_LH:  data_ext = {{16{lane[15]}}, lane[15:0]};
      FUNCT3_LW:  data_ext = rdata;
      FUNCT3_LBU: data_ext = {24'h000000, lane[7:0]};
      FUNCT3_LHU: data_ext = {16'h0000, lane[15:0]};
      default:    data_ext = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: one req/gnt + rvalid bus transaction per core
// request, with byte enables, store lane replication and load extension.
// Optional: define LSU_TIMEOUT_EN to bound REQ/WAIT time by TIMEOUT_CYCLES.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = lsu_mem_stage_pkg::DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  MemRead_i,
  input  logic                  MemWrite_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  misaligned_o,
  output logic                  err_o,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  // Only the 32-bit datapath is implemented
  if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1) begin : g_cfg_err
    $error("lsu_mem_stage: unsupported parameter configuration");
  end

  lsu_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q, rdata_q, load_ext;
  logic [2:0]            funct3_q;
  logic [3:0]            be_q;
  logic                  we_q, mis_q, err_q;
  logic                  accept, dec_err, dec_mis, dec_none, timeout;
  logic [3:0]            be_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic                  in_req;

  assign accept = req_valid_i && (state_q == LSU_IDLE);
  assign in_req = (state_q == LSU_REQ);

  // Request classification at acceptance; exactly one outcome applies
  always_comb begin
    dec_err  = 1'b0;
    dec_mis  = 1'b0;
    dec_none = 1'b0;
    if (MemRead_i && MemWrite_i) begin
      dec_err = 1'b1;
    end else if (MemRead_i && !(funct3_i inside {FUNCT3_LB, FUNCT3_LH, FUNCT3_LW,
                                                 FUNCT3_LBU, FUNCT3_LHU})) begin
      dec_err = 1'b1;
    end else if (MemWrite_i && !(funct3_i inside {FUNCT3_SB, FUNCT3_SH, FUNCT3_SW})) begin
      dec_err = 1'b1;
    end else if (!MemRead_i && !MemWrite_i) begin
      dec_none = 1'b1;
    end else if ((funct3_i[1:0] == 2'b01 && addr_i[0]) ||
                 (funct3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00)) begin
      dec_mis = 1'b1;
    end
  end

  // Byte enables and lane-replicated store data from access size
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_d    = 4'b0001 << addr_i[1:0];
        wdata_d = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << {addr_i[1], 1'b0};
        wdata_d = {2{wdata_i[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = wdata_i;
      end
    endcase
  end

  lsu_load_extend u_load_extend (
    .rdata    (mem_rdata_i),
    .addr_lsb (addr_q[1:0]),
    .funct3   (funct3_q),
    .data_ext (load_ext)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  assign timeout = (state_q == LSU_REQ || state_q == LSU_WAIT) &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Cycles spent in the current REQ/WAIT visit; cleared on any state change
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (state_q == LSU_REQ || state_q == LSU_WAIT) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= LSU_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (accept) state_d = (dec_err || dec_mis || dec_none) ? LSU_RESP : LSU_REQ;
      LSU_REQ:  if (mem_gnt_i) state_d = LSU_WAIT;
                else if (timeout) state_d = LSU_RESP;
      LSU_WAIT: if (mem_rvalid_i || timeout) state_d = LSU_RESP;
      LSU_RESP: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  // Captured request and response registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
      mis_q    <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept) begin
      addr_q   <= addr_i;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_i;
      be_q     <= be_d;
      we_q     <= MemWrite_i;
      rdata_q  <= '0;
      mis_q    <= dec_mis;
      err_q    <= dec_err;
    end else begin
      case (state_q)
        LSU_REQ:  if (!mem_gnt_i && timeout) err_q <= 1'b1;
        LSU_WAIT: begin
          if (mem_rvalid_i) rdata_q <= we_q ? '0 : load_ext;
          else if (timeout) err_q <= 1'b1;
        end
        LSU_RESP: begin
          rdata_q <= '0;
          mis_q   <= 1'b0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o  = (state_q == LSU_IDLE);
  assign rsp_valid_o  = (state_q == LSU_RESP);
  assign rdata_o      = rdata_q;
  assign misaligned_o = mis_q;
  assign err_o        = err_q;
  assign stall_o      = (state_q == LSU_IDLE && req_valid_i) || state_q == LSU_REQ ||
                        state_q == LSU_WAIT;
  assign mem_req_o    = in_req;
  assign mem_we_o     = in_req && we_q;
  assign mem_addr_o   = in_req ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
  assign mem_be_o     = in_req ? be_q : 4'b0000;
  assign mem_wdata_o  = in_req ? wdata_q : '0;

endmodule
